// File: rtl/word_seq_ctl.sv
// Word-time sequencer and instruction issuer for the ARC arithmetic register circuit.
// Runs the system counter, fetches and serializes instructions, and steps the program address.
module word_seq_ctl #(
   parameter int WORD_LEN   = 56,
   parameter int SYNC_FIRST = 45,
   parameter int IS_BITS    = 10,
   parameter int ADR_W      = 8
) (
   input  logic               cph2,
   input  logic               rstb,
   input  logic               run,
   input  logic [IS_BITS-1:0] rom_data,
   input  logic               carry,
   output logic [ADR_W-1:0]   rom_adr,
   output logic [5:0]         sys_cnt,
   output logic               sync,
   output logic               is,
   output logic               word_end
);

   localparam logic [5:0]       CNT_LAST  = 6'(WORD_LEN - 1);
   localparam logic [5:0]       CNT_FETCH = 6'(SYNC_FIRST - 1);
   localparam logic [5:0]       SYNC_LO   = 6'(SYNC_FIRST);
   localparam logic [5:0]       SYNC_HI   = 6'(SYNC_FIRST + IS_BITS - 1);
   localparam int               IDX_W     = $clog2(IS_BITS);
   localparam logic [ADR_W-1:0] ADR_ONE   = {{(ADR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_INCR = 2'd1,
      ACT_JUMP = 2'd2
   } adr_act_e;

   logic [5:0]         cnt_r;
   logic [ADR_W-1:0]   adr_r;
   logic [IS_BITS-1:0] ir_r;
   logic               carry_acc_r;
   logic               carry_prev_r;
   logic               halt_w_r;
   logic               sync_r;
   logic               is_r;
   logic               word_end_r;

   logic [5:0]         cnt_nxt_s;
   logic [ADR_W-1:0]   adr_nxt_s;
   logic [IS_BITS-1:0] ir_nxt_s;
   logic               carry_acc_nxt_s;
   logic               carry_prev_nxt_s;
   logic               halt_w_nxt_s;
   logic               sync_nxt_s;
   logic               is_nxt_s;
   logic               word_end_nxt_s;
   logic               last_s;
   logic [IDX_W-1:0]   bit_idx_s;
   adr_act_e           adr_act_s;

   // Next-state decode: counter, fetch, carry tracking, address decision and look-ahead outputs.
   always_comb begin
      cnt_nxt_s        = 6'd0;
      adr_nxt_s        = adr_r;
      ir_nxt_s         = ir_r;
      carry_acc_nxt_s  = carry_acc_r;
      carry_prev_nxt_s = carry_prev_r;
      halt_w_nxt_s     = halt_w_r;
      sync_nxt_s       = 1'b0;
      is_nxt_s         = 1'b0;
      word_end_nxt_s   = 1'b0;
      bit_idx_s        = {IDX_W{1'b0}};
      adr_act_s        = ACT_HOLD;
      last_s           = (cnt_r == CNT_LAST);

      if (last_s) begin
         cnt_nxt_s = 6'd0;
      end else begin
         cnt_nxt_s = cnt_r + 6'd1;
      end

      if (cnt_r == CNT_FETCH) begin
         if (halt_w_r) begin
            ir_nxt_s = {IS_BITS{1'b0}};
         end else begin
            ir_nxt_s = rom_data;
         end
      end else begin
         ir_nxt_s = ir_r;
      end

      // Carry arriving on the last state still belongs to the word now ending.
      if (last_s) begin
         carry_acc_nxt_s  = 1'b0;
         carry_prev_nxt_s = carry_acc_r | carry;
      end else begin
         carry_acc_nxt_s  = carry_acc_r | carry;
         carry_prev_nxt_s = carry_prev_r;
      end

      // A halted word issued a forced NOP, so resuming re-issues the held address.
      if (last_s) begin
         if (!run) begin
            adr_act_s    = ACT_HOLD;
            halt_w_nxt_s = 1'b1;
         end else begin
            halt_w_nxt_s = 1'b0;
            case (ir_r[1:0])
               2'b01: adr_act_s = ACT_JUMP;
               2'b11: begin
                  if (carry_prev_r) begin
                     adr_act_s = ACT_INCR;
                  end else begin
                     adr_act_s = ACT_JUMP;
                  end
               end
               default: begin
                  if (halt_w_r) begin
                     adr_act_s = ACT_HOLD;
                  end else begin
                     adr_act_s = ACT_INCR;
                  end
               end
            endcase
         end
      end else begin
         adr_act_s    = ACT_HOLD;
         halt_w_nxt_s = halt_w_r;
      end

      case (adr_act_s)
         ACT_JUMP: adr_nxt_s = ir_r[ADR_W+1:2];
         ACT_INCR: adr_nxt_s = adr_r + ADR_ONE;
         default:  adr_nxt_s = adr_r;
      endcase

      // Outputs are registered, so they are decoded from the next counter and ir values.
      sync_nxt_s     = (cnt_nxt_s >= SYNC_LO) && (cnt_nxt_s <= SYNC_HI);
      word_end_nxt_s = (cnt_nxt_s == CNT_LAST);
      bit_idx_s      = IDX_W'(cnt_nxt_s - SYNC_LO);
      if (sync_nxt_s) begin
         is_nxt_s = ir_nxt_s[bit_idx_s];
      end else begin
         is_nxt_s = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge cph2) begin
      if (!rstb) begin
         cnt_r        <= 6'd0;
         adr_r        <= {ADR_W{1'b0}};
         ir_r         <= {IS_BITS{1'b0}};
         carry_acc_r  <= 1'b0;
         carry_prev_r <= 1'b0;
         halt_w_r     <= 1'b0;
         sync_r       <= 1'b0;
         is_r         <= 1'b0;
         word_end_r   <= 1'b0;
      end else begin
         cnt_r        <= cnt_nxt_s;
         adr_r        <= adr_nxt_s;
         ir_r         <= ir_nxt_s;
         carry_acc_r  <= carry_acc_nxt_s;
         carry_prev_r <= carry_prev_nxt_s;
         halt_w_r     <= halt_w_nxt_s;
         sync_r       <= sync_nxt_s;
         is_r         <= is_nxt_s;
         word_end_r   <= word_end_nxt_s;
      end
   end

   assign rom_adr  = adr_r;
   assign sys_cnt  = cnt_r;
   assign sync     = sync_r;
   assign is       = is_r;
   assign word_end = word_end_r;

endmodule

// File: tb/tb_word_seq_ctl.sv
// Scoreboard bench for word_seq_ctl: stimulus queues expected addresses and is bits per word,
// a negedge monitor pops and compares them, plus per-cycle counter/window checks.
module tb_word_seq_ctl;

   logic       cph2 = 1'b0;
   logic       rstb = 1'b0;
   logic       run = 1'b1;
   logic       carry = 1'b0;
   logic [9:0] rom_data;
   logic [7:0] rom_adr;
   logic [5:0] sys_cnt;
   logic       sync;
   logic       is;
   logic       word_end;

   logic [9:0] rom [0:255];
   assign rom_data = rom[rom_adr];

   word_seq_ctl dut (
      .cph2(cph2), .rstb(rstb), .run(run), .rom_data(rom_data), .carry(carry),
      .rom_adr(rom_adr), .sys_cnt(sys_cnt), .sync(sync), .is(is), .word_end(word_end)
   );

   initial forever #5 cph2 = ~cph2;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         pos = 0;
   int         mon_cnt = 0;
   bit         mon_en = 1'b0;
   logic [7:0] cur_adr = 8'd0;
   logic [7:0] adr_q[$];
   bit         is_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_word(input logic [7:0] a, input logic [9:0] ir);
      adr_q.push_back(a);
      for (int i = 0; i < 10; i++) is_q.push_back(ir[i]);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 10'd0;
   endtask

   task automatic tick();
      @(posedge cph2);
      #2;
      pos++;
   endtask

   task automatic go_to(input int t);
      while (pos < t) tick();
   endtask

   task automatic start();
      mon_en = 1'b0;
      rstb = 1'b0;
      @(posedge cph2);
      #2;
      rstb = 1'b1;
      cyc = 0;
      pos = 0;
      adr_q.delete();
      is_q.delete();
      mon_en = 1'b1;
   endtask

   task automatic finish_seg(input int nwords);
      go_to(nwords * 56);
      mon_en = 1'b0;
      chk("leftover_expected", adr_q.size() + is_q.size(), 0);
   endtask

   // Monitor: counter/window every cycle, address at each word start, is bit whenever sync is up.
   initial forever begin
      @(negedge cph2);
      if (mon_en) begin
         mon_cnt = cyc % 56;
         chk("sys_cnt", sys_cnt, mon_cnt);
         chk("sync", sync, (mon_cnt >= 45 && mon_cnt <= 54) ? 1 : 0);
         chk("word_end", word_end, (mon_cnt == 55) ? 1 : 0);
         if (mon_cnt == 0) begin
            if (adr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL adr_underrun: got word start expected none (cyc %0d)", cyc);
            end else begin
               cur_adr = adr_q.pop_front();
            end
         end
         chk("rom_adr", rom_adr, cur_adr);
         if (sync) begin
            if (is_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL is_underrun: got sync expected none (cyc %0d)", cyc);
            end else begin
               chk("is", is, is_q.pop_front());
            end
         end else begin
            chk("is_idle", is, 0);
         end
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: free run with an all-NOP ROM
      clear_rom();
      start();
      for (int w = 0; w < 4; w++) push_word(8'(w), 10'd0);
      finish_seg(4);

      // 2: serialization, LSB first
      clear_rom();
      rom[0] = 10'b11101_010_00;
      rom[1] = 10'b11111_000_10;
      start();
      push_word(8'h00, 10'b1110101000);
      push_word(8'h01, 10'b1111100010);
      push_word(8'h02, 10'd0);
      finish_seg(3);

      // 3: unconditional jump from 3 to 0x28
      clear_rom();
      rom[3]     = {8'h28, 2'b01};
      rom[8'h28] = 10'b1010011000;
      start();
      for (int w = 0; w < 3; w++) push_word(8'(w), 10'd0);
      push_word(8'h03, 10'b0010100001);
      push_word(8'h28, 10'b1010011000);
      push_word(8'h29, 10'd0);
      finish_seg(6);

      // 4: branch-if-no-carry at 5 to 0x40 with four carry placements
      for (int k = 0; k < 4; k++) begin
         clear_rom();
         rom[5] = {8'h40, 2'b11};
         start();
         for (int w = 0; w < 5; w++) push_word(8'(w), 10'd0);
         push_word(8'h05, 10'b0100000011);
         if (k == 1) begin
            push_word(8'h06, 10'd0);
            push_word(8'h07, 10'd0);
         end else begin
            push_word(8'h40, 10'd0);
            push_word(8'h41, 10'd0);
         end
         if (k == 1) go_to(4 * 56 + 20);
         if (k == 2) go_to(5 * 56 + 20);
         if (k == 3) go_to(5 * 56 + 55);
         if (k != 0) begin
            carry = 1'b1;
            tick();
            carry = 1'b0;
         end
         finish_seg(8);
      end

      // 5: halt for three words while at address 3, then resume
      clear_rom();
      rom[3] = 10'b0110011000;
      start();
      for (int w = 0; w < 3; w++) push_word(8'(w), 10'd0);
      push_word(8'h03, 10'b0110011000);
      for (int w = 0; w < 3; w++) push_word(8'h03, 10'd0);
      push_word(8'h03, 10'b0110011000);
      push_word(8'h04, 10'd0);
      go_to(3 * 56 + 10);
      run = 1'b0;
      go_to(6 * 56 + 10);
      run = 1'b1;
      finish_seg(9);

      // 6: address wrap FF -> 00, then reset in the middle of a word
      clear_rom();
      rom[0] = {8'hFE, 2'b01};
      start();
      push_word(8'h00, 10'b1111111001);
      push_word(8'hFE, 10'd0);
      push_word(8'hFF, 10'd0);
      push_word(8'h00, 10'b1111111001);
      push_word(8'hFE, 10'd0);
      finish_seg(5);
      go_to(5 * 56 + 30);
      chk("pre_reset_cnt", sys_cnt, 30);
      chk("pre_reset_adr", rom_adr, 8'hFF);
      rstb = 1'b0;
      tick();
      chk("mid_reset_cnt", sys_cnt, 0);
      chk("mid_reset_adr", rom_adr, 0);
      chk("mid_reset_sync", sync, 0);
      chk("mid_reset_is", is, 0);
      chk("mid_reset_word_end", word_end, 0);
      rstb = 1'b1;
      cyc = 0;
      pos = 0;
      adr_q.delete();
      is_q.delete();
      push_word(8'h00, 10'b1111111001);
      push_word(8'hFE, 10'd0);
      mon_en = 1'b1;
      finish_seg(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
